// File: rtl/tnn_feature_loader.sv
// Serial-to-parallel feature loader for a combinational ternary classifier.
// Collects NUM_FEAT beats, gives the classifier a settling cycle, and holds the result.
module tnn_feature_loader #(
    parameter int unsigned NUM_FEAT = 5,
    parameter int unsigned FEAT_W   = 3,
    parameter int unsigned IDX_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_vec,
    input  logic                       cls_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_class,
    output logic [IDX_W-1:0]           m_index,
    output logic                       err_frame
);

    localparam int unsigned CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int unsigned VEC_W = NUM_FEAT * FEAT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FEAT - 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DROP    = 2'd1;
    localparam logic [1:0] ST_EVAL    = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] feat_q, feat_d;
    logic             class_q, class_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             err_q, err_d;
    logic             beat;

    assign s_ready = (state_q == ST_COLLECT) || (state_q == ST_DROP);
    assign beat    = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        feat_d  = feat_q;
        class_d = class_q;
        index_d = index_q;
        err_d   = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (beat) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (s_last) begin
                            feat_d[int'(cnt_q)*FEAT_W +: FEAT_W] = s_data;
                            state_d = ST_EVAL;
                        end else begin
                            // Long frame: flag once, then swallow the rest of it in DROP.
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else if (s_last) begin
                        // Short frame: earlier slots are kept, the next beat restarts at slot 0.
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        feat_d[int'(cnt_q)*FEAT_W +: FEAT_W] = s_data;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (beat && s_last) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_EVAL: begin
                // feat_vec has been stable for a full cycle; capture the settled decision.
                class_d = cls_in;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (m_ready) begin
                    index_d = index_q + IDX_W'(1);
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            feat_q  <= '0;
            class_q <= 1'b0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            feat_q  <= feat_d;
            class_q <= class_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    assign feat_vec  = feat_q;
    assign m_valid   = (state_q == ST_HOLD);
    assign m_class   = class_q;
    assign m_index   = index_q;
    assign err_frame = err_q;

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Self-checking bench for tnn_feature_loader: fixed frame table, corner-case sequences
// and randomized framing checked against a transaction-level reference model.
module tb_tnn_feature_loader;

    localparam int NF = 5;
    localparam int FW = 3;
    localparam int IW = 8;
    localparam int VW = NF * FW;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [FW-1:0] s_data;
    logic          s_last;
    logic [VW-1:0] feat_vec;
    logic          cls_in;
    logic          m_valid;
    logic          m_ready;
    logic          m_class;
    logic [IW-1:0] m_index;
    logic          err_frame;

    tnn_feature_loader #(
        .NUM_FEAT(NF),
        .FEAT_W  (FW),
        .IDX_W   (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .feat_vec (feat_vec),
        .cls_in   (cls_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
        .m_index  (m_index),
        .err_frame(err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Classifier under the loader: input_a greater than the sum of the other four.
    int rest_sum;
    always_comb begin
        rest_sum = int'(feat_vec[5:3]) + int'(feat_vec[8:6]) + int'(feat_vec[11:9])
                 + int'(feat_vec[14:12]);
        cls_in = (int'(feat_vec[2:0]) > rest_sum);
    end

    typedef struct packed {
        logic [VW-1:0] vec;
        logic          cls;
    } res_t;

    typedef struct {
        int            beats [NF];
        logic [VW-1:0] exp_vec;
        logic          exp_class;
    } vec_t;

    res_t          exp_q[$];
    logic [IW-1:0] exp_index;
    int            n_vec;
    int            n_err;
    int            err_seen;
    int            err_exp;
    bit            rand_ready;
    bit            wait_prev;
    logic          prev_class;
    logic [IW-1:0] prev_index;
    vec_t          tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Observes the cycle about to be clocked (inputs already applied, outputs settled).
    task automatic monitor();
        res_t r;
        if (m_valid) begin
            chk("s_ready_low_in_hold", 32'(s_ready), 32'd0);
            if (wait_prev) begin
                chk("hold_class_stable", 32'(m_class), 32'(prev_class));
                chk("hold_index_stable", 32'(m_index), 32'(prev_index));
            end
            if (exp_q.size() == 0) begin
                fail_now("spurious_m_valid");
            end else if (m_ready) begin
                r = exp_q.pop_front();
                chk("m_class", 32'(m_class), 32'(r.cls));
                chk("feat_vec", 32'(feat_vec), 32'(r.vec));
                chk("m_index", 32'(m_index), 32'(exp_index));
                exp_index = exp_index + 1'b1;
            end
        end
        if (err_frame === 1'b1) err_seen++;
        wait_prev  = m_valid && !m_ready;
        prev_class = m_class;
        prev_index = m_index;
    endtask

    task automatic cycle();
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
        monitor();
        @(negedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [FW-1:0] d, input logic l);
        int  waited;
        bit  acc;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            acc = s_ready;
            cycle();
            if (acc) break;
            waited++;
            if (waited > 60) begin
                fail_now("beat_accept_timeout");
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0) begin
            cycle();
            budget++;
            if (budget > 200) begin
                fail_now("drain_timeout");
                exp_q.delete();
            end
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_class", 32'(m_class), 32'd0);
        chk("rst_m_index", 32'(m_index), 32'd0);
        chk("rst_err_frame", 32'(err_frame), 32'd0);
        chk("rst_feat_vec", 32'(feat_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_q.delete();
        exp_index = '0;
        wait_prev = 1'b0;
    endtask

    // Reference model: a frame of exactly NF beats yields one result, anything else one error.
    task automatic send_frame(input int len, input bit gaps);
        logic [FW-1:0] d [16];
        res_t          r;
        int            sum;
        r   = '0;
        sum = 0;
        for (int k = 0; k < len; k++) d[k] = FW'($urandom_range(0, 7));
        if (len == NF) begin
            for (int k = 0; k < NF; k++) r.vec[k*FW +: FW] = d[k];
            for (int k = 1; k < NF; k++) sum += int'(d[k]);
            r.cls = (int'(d[0]) > sum);
            exp_q.push_back(r);
        end else begin
            err_exp++;
        end
        for (int k = 0; k < len; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cycle();
            send_beat(d[k], (k == len - 1));
        end
    endtask

    task automatic send_table(input int i);
        res_t r;
        r.vec = tbl[i].exp_vec;
        r.cls = tbl[i].exp_class;
        exp_q.push_back(r);
        for (int k = 0; k < NF; k++) send_beat(FW'(tbl[i].beats[k]), (k == NF - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; err_seen = 0; err_exp = 0;
        rand_ready = 1'b0; wait_prev = 1'b0; exp_index = '0;
        prev_class = 1'b0; prev_index = '0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

        tbl[0].beats = '{3, 2, 1, 4, 5}; tbl[0].exp_vec = 15'b101_100_001_010_011;
        tbl[0].exp_class = 1'b0;
        tbl[1].beats = '{7, 1, 0, 2, 1}; tbl[1].exp_vec = 15'b001_010_000_001_111;
        tbl[1].exp_class = 1'b1;
        tbl[2].beats = '{0, 0, 0, 0, 0}; tbl[2].exp_vec = 15'b000_000_000_000_000;
        tbl[2].exp_class = 1'b0;
        tbl[3].beats = '{7, 7, 7, 7, 7}; tbl[3].exp_vec = 15'b111_111_111_111_111;
        tbl[3].exp_class = 1'b0;
        tbl[4].beats = '{1, 0, 0, 0, 0}; tbl[4].exp_vec = 15'b000_000_000_000_001;
        tbl[4].exp_class = 1'b1;
        tbl[5].beats = '{4, 1, 1, 1, 0}; tbl[5].exp_vec = 15'b000_001_001_001_100;
        tbl[5].exp_class = 1'b1;

        @(negedge clk);
        #1;
        do_reset();

        // Table frames with latency and single-cycle m_valid checks.
        for (int i = 0; i < 6; i++) begin
            send_table(i);
            chk("eval_m_valid_low", 32'(m_valid), 32'd0);
            chk("eval_s_ready_low", 32'(s_ready), 32'd0);
            cycle();
            chk("latency_m_valid", 32'(m_valid), 32'd1);
            chk("latency_feat_vec", 32'(feat_vec), 32'(tbl[i].exp_vec));
            cycle();
            chk("m_valid_one_cycle", 32'(m_valid), 32'd0);
            chk("collect_s_ready", 32'(s_ready), 32'd1);
        end

        // Short frame, then a good frame starting from index 0.
        do_reset();
        send_beat(3'd5, 1'b0);
        send_beat(3'd6, 1'b1);
        err_exp++;
        chk("short_err_pulse", 32'(err_frame), 32'd1);
        cycle();
        chk("short_err_one_cycle", 32'(err_frame), 32'd0);
        repeat (3) begin
            cycle();
            chk("short_no_m_valid", 32'(m_valid), 32'd0);
        end
        send_frame(NF, 1'b0);
        drain();

        // Long frame of 7 beats: error on beat 5, beats 6-7 dropped silently.
        for (int k = 0; k < 5; k++) send_beat(FW'(k + 1), 1'b0);
        err_exp++;
        chk("long_err_pulse", 32'(err_frame), 32'd1);
        send_beat(3'd6, 1'b0);
        chk("drop_no_err", 32'(err_frame), 32'd0);
        send_beat(3'd7, 1'b1);
        chk("drop_last_no_err", 32'(err_frame), 32'd0);
        chk("drop_no_m_valid", 32'(m_valid), 32'd0);
        cycle();
        chk("after_drop_s_ready", 32'(s_ready), 32'd1);
        send_table(1);
        drain();

        // Downstream stall in HOLD.
        m_ready = 1'b0;
        send_table(5);
        repeat (12) cycle();
        chk("stall_m_valid", 32'(m_valid), 32'd1);
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        cycle();
        chk("release_m_valid", 32'(m_valid), 32'd0);
        chk("release_s_ready", 32'(s_ready), 32'd1);

        // Reset mid-frame, then reset while holding a result.
        send_beat(3'd1, 1'b0);
        send_beat(3'd2, 1'b0);
        send_beat(3'd3, 1'b0);
        do_reset();
        send_table(4);
        drain();
        m_ready = 1'b0;
        send_table(3);
        repeat (4) cycle();
        chk("pre_reset_hold", 32'(m_valid), 32'd1);
        do_reset();
        m_ready = 1'b1;
        send_table(0);
        drain();

        // Index wrap: 257 back-to-back frames from reset.
        do_reset();
        for (int f = 0; f < 257; f++) begin
            send_frame(NF, 1'b0);
            drain();
        end
        chk("wrap_index_after_257", 32'(m_index), 32'd1);

        // Randomized framing, gaps and backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : NF;
            send_frame(len, 1'b1);
        end
        drain();
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        repeat (4) cycle();
        chk("err_frame_count", 32'(err_seen), 32'(err_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
